// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the multicycle-datapath memory responder.
package mc_mem_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    // Access-size encoding carried on byte_acc.
    localparam logic ACC_WORD = 1'b0;
    localparam logic ACC_BYTE = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Request captured at the accept edge; bad marks a request that must not
    // touch the array and returns zero read data.
    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic              byte_acc;
        logic              is_read;
        logic              is_write;
        logic              bad;
    } req_t;

    // Classify a request as illegal: conflicting direction, misaligned word
    // access, or address bits set above the word-index range.
    function automatic logic req_error(
        input logic              rd,
        input logic              wr,
        input logic              bacc,
        input logic [WORD_W-1:0] addr,
        input int                idx_w
    );
        logic conflict;
        logic misaligned;
        logic out_of_range;
        conflict     = rd & wr;
        misaligned   = (bacc == ACC_WORD) & addr[0];
        out_of_range = ((addr >> (idx_w + 1)) != '0);
        return conflict | misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response and preload signals between the datapath controller and
// the memory responder.
interface mem_responder_if;
    import mc_mem_pkg::*;

    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              mem_read;
    logic              mem_write;
    logic              byte_acc;
    logic              ld_en;
    logic [WORD_W-1:0] ld_addr;
    logic [WORD_W-1:0] ld_data;
    logic [WORD_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    // Initiator side (datapath controller / preload source).
    modport master (
        output addr, wdata, mem_read, mem_write, byte_acc,
        output ld_en, ld_addr, ld_data,
        input  rdata, ready, busy, err
    );

    // Responder side (memory).
    modport slave (
        input  addr, wdata, mem_read, mem_write, byte_acc,
        input  ld_en, ld_addr, ld_data,
        output rdata, ready, busy, err
    );

endinterface

// File: rtl/mem_byte_lane_merge.sv
// Byte-lane helper: builds the word to write back and extracts the byte for
// lb. Purely combinational.
module mem_byte_lane_merge
    import mc_mem_pkg::*;
(
    input  logic [WORD_W-1:0] old_word,
    input  logic [BYTE_W-1:0] wbyte,
    input  logic [WORD_W-1:0] wword,
    input  logic              lane,
    input  logic              byte_acc,
    output logic [WORD_W-1:0] merged,
    output logic [BYTE_W-1:0] rd_byte
);

    localparam int LANES = WORD_W / BYTE_W;

    // Each lane takes the new byte only when it is the addressed lane of a
    // byte store; word stores replace every lane.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam logic LANE_ID = 1'(gi);
        assign merged[gi*BYTE_W +: BYTE_W] =
            (byte_acc == ACC_BYTE) ?
                ((lane == LANE_ID) ? wbyte : old_word[gi*BYTE_W +: BYTE_W]) :
                wword[gi*BYTE_W +: BYTE_W];
    end

    assign rd_byte = lane ? old_word[2*BYTE_W-1:BYTE_W] : old_word[BYTE_W-1:0];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: unified instruction/data store with word
// and byte access, a preload port and a sticky illegal-access flag.
module mem_responder
    import mc_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
)
(
    input  logic          clk,
    input  logic          rst,
    mem_responder_if.slave bus
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    req_t              req_reg;
    logic              err_reg;
    logic [WORD_W-1:0] rdata_hold_reg;
    logic [WORD_W-1:0] rd_word_reg;
    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    logic              req_present;
    logic              accept;
    logic              in_bad;
    logic [IDX_W-1:0]  in_idx;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  ld_idx;
    logic              ld_in_range;
    logic              preload_fire;
    logic              commit;
    logic [WORD_W-1:0] merged_word;
    logic [BYTE_W-1:0] rd_byte;
    logic [WORD_W-1:0] rd_value;
    logic              ready_out;
    logic              busy_out;
    logic [WORD_W-1:0] rdata_out;

    assign req_present = bus.mem_read | bus.mem_write;
    assign accept      = (state_reg == IDLE) & req_present;
    assign in_bad      = req_error(bus.mem_read, bus.mem_write, bus.byte_acc,
                                   bus.addr, IDX_W);

    assign in_idx  = bus.addr[IDX_W:1];
    assign req_idx = req_reg.addr[IDX_W:1];
    // In IDLE the array is read at the incoming address so the word is
    // already registered when LATENCY is 1; afterwards the latched address
    // keeps it fresh.
    assign rd_idx  = (state_reg == IDLE) ? in_idx : req_idx;

    assign ld_idx       = bus.ld_addr[IDX_W-1:0];
    assign ld_in_range  = ((bus.ld_addr >> IDX_W) == '0);
    assign preload_fire = ~rst & (state_reg == IDLE) & ~req_present &
                          bus.ld_en & ld_in_range;
    assign commit       = ~rst & (state_reg == DONE) & req_reg.is_write &
                          ~req_reg.bad;

    mem_byte_lane_merge u_lane_merge (
        .old_word (rd_word_reg),
        .wbyte    (req_reg.wdata[BYTE_W-1:0]),
        .wword    (req_reg.wdata),
        .lane     (req_reg.addr[0]),
        .byte_acc (req_reg.byte_acc),
        .merged   (merged_word),
        .rd_byte  (rd_byte)
    );

    // Errored reads return zero; byte reads are zero-extended.
    assign rd_value = req_reg.bad ? '0 :
                      (req_reg.byte_acc == ACC_BYTE) ?
                          {{(WORD_W-BYTE_W){1'b0}}, rd_byte} : rd_word_reg;

    // State and wait-counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state, counter and handshake outputs.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ready_out  = 1'b0;
        busy_out   = 1'b0;
        rdata_out  = rdata_hold_reg;
        case (state_reg)
            IDLE: begin
                if (req_present) begin
                    busy_out   = 1'b1;
                    cnt_next   = CNT_LOAD;
                    state_next = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                busy_out = 1'b1;
                cnt_next = cnt_reg - 4'd1;
                if (cnt_next == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_out   = 1'b1;
                ready_out  = 1'b1;
                state_next = IDLE;
                if (req_reg.is_read) begin
                    rdata_out = rd_value;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch, sticky error flag and held read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_reg        <= '0;
            err_reg        <= 1'b0;
            rdata_hold_reg <= '0;
        end else begin
            if (accept) begin
                req_reg.addr     <= bus.addr;
                req_reg.wdata    <= bus.wdata;
                req_reg.byte_acc <= bus.byte_acc;
                req_reg.is_read  <= bus.mem_read;
                req_reg.is_write <= bus.mem_write;
                req_reg.bad      <= in_bad;
                if (in_bad) begin
                    err_reg <= 1'b1;
                end
            end
            if ((state_reg == DONE) && req_reg.is_read) begin
                rdata_hold_reg <= rd_value;
            end
        end
    end

    // Storage array: one registered read port, one write port shared by
    // request commits (DONE only) and preloads (IDLE only). Not cleared by rst.
    always_ff @(posedge clk) begin
        rd_word_reg <= mem[rd_idx];
        if (commit) begin
            mem[req_idx] <= merged_word;
        end else if (preload_fire) begin
            mem[ld_idx] <= bus.ld_data;
        end
    end

    assign bus.rdata = rdata_out;
    assign bus.ready = ready_out;
    assign bus.busy  = busy_out;
    assign bus.err   = err_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// traffic checked against a word-array reference model.
module tb_mem_responder;
    import mc_mem_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_responder_if bus();

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          txn      = 0;
    int          last_ready_cyc = 0;
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] exp_rdata = 16'h0000;
    logic        exp_err   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic ld(input logic [15:0] idx, input logic [15:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = idx;
        bus.ld_data = d;
        tick();
        bus.ld_en = 1'b0;
        if (int'(idx) < DEPTH) ref_mem[int'(idx)] = d;
    endtask

    // One request: drive, wait (bounded) for ready, compare with the model.
    task automatic do_req(input bit rd, input bit wr, input bit bacc,
                          input logic [15:0] a, input logic [15:0] wd,
                          input bit drop, input bit hold);
        bit          bad;
        bit          seen;
        int          idx;
        int          cycles;
        logic [15:0] word;
        logic [15:0] want;
        bad  = (rd && wr) || (!bacc && a[0]) || (int'(a) >= 2 * DEPTH);
        idx  = (int'(a) / 2) % DEPTH;
        word = ref_mem[idx];
        if (bad)       want = 16'h0000;
        else if (bacc) want = a[0] ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
        else           want = word;

        bus.addr = a; bus.wdata = wd; bus.byte_acc = bacc;
        bus.mem_read = rd; bus.mem_write = wr;
        #1;
        check("busy_accept", bus.busy, 1);

        seen = 0; cycles = 0;
        while (!seen && cycles < 32) begin
            tick();
            cycles++;
            bus.ld_en = 1'b0;
            if (drop) clear_req();
            if (bus.ready) seen = 1;
            else check("busy_wait", bus.busy, 1);
        end
        check("latency", cycles, LAT);
        exp_err = exp_err | bad;
        if (rd) exp_rdata = want;
        if (seen) begin
            check("busy_done", bus.busy, 1);
            check(rd ? "rdata" : "rdata_held", bus.rdata, exp_rdata);
            check("err", bus.err, exp_err);
        end
        $display("txn %0d: rd=%0b wr=%0b byte=%0b addr=%04h wdata=%04h -> rdata=%04h err=%0b lat=%0d",
                 txn, rd, wr, bacc, a, wd, bus.rdata, bus.err, cycles);
        txn++;
        last_ready_cyc = cyc;
        if (!hold) clear_req();
        if (wr && !bad) begin
            if (!bacc)     ref_mem[idx] = wd;
            else if (a[0]) ref_mem[idx][15:8] = wd[7:0];
            else           ref_mem[idx][7:0]  = wd[7:0];
        end
        tick();
        check("ready_pulse", bus.ready, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_req();
        bus.ld_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        exp_rdata = 16'h0000;
    endtask

    initial begin
        int          t1;
        bit          r_rd;
        bit          r_b;
        logic [15:0] r_a;

        bus.addr = '0; bus.wdata = '0; bus.mem_read = 0; bus.mem_write = 0;
        bus.byte_acc = 0; bus.ld_en = 0; bus.ld_addr = '0; bus.ld_data = '0;

        // Reset state
        apply_reset();
        check("rst_ready", bus.ready, 0);
        check("rst_busy",  bus.busy,  0);
        check("rst_err",   bus.err,   0);
        check("rst_rdata", bus.rdata, 0);

        // Preload the whole array with random data, then mem[3]=BEEF
        for (int i = 0; i < DEPTH; i++) ld(16'(i), 16'($urandom));
        ld(16'd3, 16'hBEEF);
        do_req(1, 0, 0, 16'h0006, 16'h0000, 0, 0);
        check("beef", bus.rdata, 16'hBEEF);

        // Word write, byte write to upper lane, word and byte reads
        do_req(0, 1, 0, 16'h0010, 16'h1234, 0, 0);
        do_req(0, 1, 1, 16'h0011, 16'h00AB, 0, 0);
        do_req(1, 0, 0, 16'h0010, 16'h0000, 0, 0);
        check("merge_word", bus.rdata, 16'hAB34);
        do_req(1, 0, 1, 16'h0010, 16'h0000, 0, 0);
        do_req(1, 0, 1, 16'h0011, 16'h0000, 0, 0);

        // Out-of-range preload is dropped silently
        ld(16'h0100, 16'hCAFE);
        do_req(1, 0, 0, 16'h0000, 16'h0000, 0, 0);

        // Preload coinciding with a request is dropped
        bus.ld_en = 1'b1; bus.ld_addr = 16'd5; bus.ld_data = 16'hDEAD;
        do_req(1, 0, 0, 16'h000A, 16'h0000, 0, 0);
        do_req(1, 0, 0, 16'h000A, 16'h0000, 0, 0);

        // Back-to-back with request held through ready, then drop in WAIT
        do_req(1, 0, 0, 16'h0006, 16'h0000, 0, 1);
        t1 = last_ready_cyc;
        do_req(1, 0, 0, 16'h0006, 16'h0000, 0, 0);
        check("b2b_period", last_ready_cyc - t1, LAT + 1);
        do_req(1, 0, 0, 16'h0010, 16'h0000, 1, 0);

        // Randomized legal traffic
        for (int n = 0; n < 60; n++) begin
            r_rd = 1'($urandom_range(0, 1));
            r_b  = 1'($urandom_range(0, 1));
            r_a  = 16'(($urandom_range(0, DEPTH - 1) << 1) |
                       (r_b ? $urandom_range(0, 1) : 0));
            do_req(r_rd, !r_rd, r_b, r_a, 16'($urandom), (n % 7) == 3, 0);
        end

        // Illegal accesses
        do_req(1, 0, 0, 16'h0003, 16'h0000, 0, 0);
        check("misaligned_rdata", bus.rdata, 16'h0000);
        do_req(1, 0, 0, 16'h0010, 16'h0000, 0, 0);
        do_req(0, 1, 0, 16'h0200, 16'h7777, 0, 0);
        do_req(1, 0, 0, 16'h0000, 16'h0000, 0, 0);
        do_req(1, 1, 0, 16'h0004, 16'h9999, 0, 0);
        do_req(1, 0, 0, 16'h0004, 16'h0000, 0, 0);
        for (int n = 0; n < 6; n++) begin
            r_rd = 1'($urandom_range(0, 1));
            do_req(r_rd, !r_rd, 1'($urandom_range(0, 1)),
                   16'($urandom_range(2 * DEPTH, 16'hFFFF)), 16'($urandom), 0, 0);
        end
        do_req(1, 0, 0, 16'h0000, 16'h0000, 0, 0);

        // Reset in WAIT of a write: no ready, no commit, outputs cleared
        ld(16'd16, 16'h5555);
        bus.addr = 16'h0020; bus.wdata = 16'hAAAA; bus.byte_acc = 0;
        bus.mem_write = 1'b1;
        tick();
        rst = 1'b1;
        clear_req();
        check("mid_rst_noready", bus.ready, 0);
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        exp_rdata = 16'h0000;
        check("mid_rst_ready", bus.ready, 0);
        check("mid_rst_busy",  bus.busy,  0);
        check("mid_rst_err",   bus.err,   0);
        check("mid_rst_rdata", bus.rdata, 0);
        tick();
        check("mid_rst_late_ready", bus.ready, 0);
        do_req(1, 0, 0, 16'h0020, 16'h0000, 0, 0);
        check("mid_rst_mem", bus.rdata, 16'h5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
